// File: rtl/ads_spi_ctrl.sv
// ads_spi_ctrl: Avalon-MM slave that runs complete ADS7843-style touch conversions in hardware
//   clk, reset_n                      system clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata, readdata, irq          Avalon-MM slave: CMD/STAT/DATA/DIV registers, irq = done & irq_en
//   ads_cs_n, ads_dclk, ads_din,
//   ads_dout, ads_penirq_n            touch-controller serial interface and pen interrupt
module ads_spi_ctrl #(
    parameter int HALF_DEFAULT = 25,
    parameter int NBITS = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        ads_cs_n,
    output logic        ads_dclk,
    output logic        ads_din,
    input  logic        ads_dout,
    input  logic        ads_penirq_n
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3;
    localparam int HP_W = $clog2(2 * NBITS);
    localparam logic [HP_W-1:0] LAST = HP_W'(2 * NBITS - 1);
    logic [1:0] state;
    logic [15:0] cnt, h, div;
    logic [7:0] cmd, sr;
    logic [HP_W-1:0] hp;
    // holds only the most recent samples; after the final rising edge the result slots sit at the top
    logic [NBITS-10:0] cap;
    logic [11:0] data;
    logic [1:0] pen_sync;
    logic done, irq_en, busy, step, wr;
    logic unused_wd;
    assign unused_wd = ^writedata[31:16];
    assign wr = chipselect & ~write_n;
    assign step = cnt == h - 16'd1;
    assign busy = state != IDLE;
    assign irq = done & irq_en;
    assign ads_cs_n = state == IDLE;
    assign ads_din = ~ads_cs_n & sr[7];
    assign readdata = address == 2'd0 ? {24'b0, cmd} :
                      address == 2'd1 ? {23'b0, irq_en, 5'b0, pen_sync[1], done, busy} :
                      address == 2'd2 ? {20'b0, data} : {16'b0, div};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            h <= 16'd1;
            div <= 16'(HALF_DEFAULT);
            cmd <= '0;
            sr <= '0;
            hp <= '0;
            cap <= '0;
            data <= '0;
            pen_sync <= '0;
            done <= 1'b0;
            irq_en <= 1'b0;
            ads_dclk <= 1'b0;
        end else begin
            pen_sync <= {pen_sync[0], ~ads_penirq_n};
            if (wr && address == 2'd1) irq_en <= writedata[8];
            if (wr && address == 2'd3) div <= writedata[15:0];
            // completion takes priority over a simultaneous W1C
            if (state == HOLD && step) done <= 1'b1;
            else if (wr && address == 2'd1 && writedata[1]) done <= 1'b0;
            cnt <= (state == IDLE || step) ? '0 : cnt + 16'd1;
            case (state)
                IDLE: if (wr && address == 2'd0) begin
                    cmd <= writedata[7:0];
                    sr <= writedata[7:0];
                    h <= (div == '0) ? 16'd1 : div;
                    state <= SETUP;
                end
                SETUP: if (step) begin
                    state <= SHIFT;
                    ads_dclk <= 1'b1;
                    hp <= '0;
                    cap <= {cap[NBITS-11:0], ads_dout};
                end
                SHIFT: if (step) begin
                    // the last half-period is low and ends without a further toggle
                    if (hp == LAST) state <= HOLD;
                    else begin
                        hp <= hp + 1'b1;
                        ads_dclk <= ~ads_dclk;
                        if (ads_dclk) sr <= {sr[6:0], 1'b0};
                        else cap <= {cap[NBITS-11:0], ads_dout};
                    end
                end
                default: if (step) begin
                    state <= IDLE;
                    data <= cap[NBITS-10 -: 12];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ads_spi_ctrl.sv
// tb_ads_spi_ctrl: self-checking bench for ads_spi_ctrl with a behavioural touch-controller model
module tb_ads_spi_ctrl;
    logic clk = 0, reset_n = 0;
    logic [1:0] address = 0;
    logic chipselect = 0, write_n = 1;
    logic [31:0] writedata = 0;
    logic [31:0] readdata;
    logic irq, ads_cs_n, ads_dclk, ads_din;
    logic ads_dout = 0, ads_penirq_n = 1;
    int checks = 0, errors = 0;
    int redge = 0, txn_cnt = 0, clk_cnt = 0, nxt;
    logic [23:0] din_vec = 0, dev_noise = 0;
    logic [11:0] dev_val = 0, exp_data = 0;

    ads_spi_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .ads_cs_n(ads_cs_n), .ads_dclk(ads_dclk), .ads_din(ads_din),
        .ads_dout(ads_dout), .ads_penirq_n(ads_penirq_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_cnt++;

    // device model: a conversion starts at the CS fall; the device shifts data out after each
    // falling DCLK edge so it is stable at the next rising edge; rising edges 10..21 carry the
    // 12-bit result MSB first, every other slot carries noise that must be discarded
    always @(negedge ads_cs_n) begin
        txn_cnt++;
        redge = 0;
        din_vec = '0;
        ads_dout = dev_noise[0];
    end
    always @(posedge ads_dclk) begin
        redge++;
        if (redge >= 1 && redge <= 24) din_vec[24-redge] = ads_din;
    end
    always @(negedge ads_dclk) begin
        nxt = redge + 1;
        if (nxt >= 10 && nxt <= 21) ads_dout = dev_val[21-nxt];
        else ads_dout = dev_noise[nxt%24];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        writedata = d;
        chipselect = 1;
        write_n = 0;
        @(negedge clk);
        chipselect = 0;
        write_n = 1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic wait_idle();
        int g = 0;
        address = 1;
        #1;
        while (readdata[0] && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
        end
    endtask

    task automatic run_txn(input logic [7:0] c, input logic [11:0] v, input int he);
        logic [31:0] r;
        int t0;
        dev_val = v;
        dev_noise = 24'($urandom);
        do_write(0, {24'b0, c});
        t0 = clk_cnt;
        rd(2, r);
        chk("data_kept_while_busy", r, {20'b0, exp_data});
        wait_idle();
        chk("busy_cycles", clk_cnt - t0, 50 * he);
        exp_data = v;
        chk("dclk_pulses", redge, 24);
        chk("din_bits", {8'b0, din_vec}, {8'b0, c, 16'b0});
        rd(2, r);
        chk("data_result", r, {20'b0, v});
        rd(1, r);
        chk("done_set", {31'b0, r[1]}, 1);
        chk("cs_released", {31'b0, ads_cs_n}, 1);
    endtask

    initial begin
        logic [31:0] r;
        int c0, t0, d, g;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'b0, ads_cs_n}, 1);
        chk("rst_dclk", {31'b0, ads_dclk}, 0);
        reset_n = 1;
        @(negedge clk);
        chk("rst_din", {31'b0, ads_din}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        rd(0, r); chk("rst_cmd", r, 0);
        rd(1, r); chk("rst_stat", r, 0);
        rd(2, r); chk("rst_data", r, 0);
        rd(3, r); chk("rst_div", r, 25);

        // basic conversion at H=2
        do_write(3, 2);
        run_txn(8'h90, 12'hABC, 2);

        // interrupt enable, completion, W1C clear
        do_write(1, 32'h102);
        chk("irq_cleared_before", {31'b0, irq}, 0);
        run_txn(8'($urandom), 12'($urandom), 2);
        chk("irq_on_done", {31'b0, irq}, 1);
        do_write(1, 32'h102);
        chk("irq_after_w1c", {31'b0, irq}, 0);
        rd(1, r);
        chk("irq_en_kept", {31'b0, r[8]}, 1);

        // CMD write while busy ignored, DIV change deferred to the next transaction
        c0 = txn_cnt;
        dev_val = 12'($urandom);
        do_write(0, 32'h90);
        t0 = clk_cnt;
        repeat (10) @(negedge clk);
        do_write(0, 32'hD0);
        do_write(3, 3);
        wait_idle();
        chk("div_deferred_cycles", clk_cnt - t0, 100);
        exp_data = dev_val;
        repeat (20) @(negedge clk);
        rd(0, r); chk("cmd_ignored", r, 32'h90);
        chk("single_txn", txn_cnt - c0, 1);
        rd(1, r); chk("not_busy", {31'b0, r[0]}, 0);
        rd(2, r); chk("data_after_busy_write", r, {20'b0, exp_data});
        run_txn(8'($urandom), 12'($urandom), 3);

        // DIV=0 behaves as H=1
        do_write(3, 0);
        rd(3, r); chk("div_zero_reads", r, 0);
        run_txn(8'($urandom), 12'($urandom), 1);

        for (int i = 0; i < 4; i++) begin
            d = $urandom_range(0, 4);
            do_write(3, d);
            run_txn(8'($urandom), 12'($urandom), d == 0 ? 1 : d);
        end

        // reset in the middle of a conversion
        do_write(3, 1);
        do_write(1, 32'h100);
        chk("irq_before_reset", {31'b0, irq}, 1);
        dev_val = 12'($urandom);
        do_write(0, 32'hA5);
        g = 0;
        while (redge < 12 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("reached_edge12", redge, 12);
        reset_n = 0;
        #1;
        chk("mid_rst_cs_n", {31'b0, ads_cs_n}, 1);
        chk("mid_rst_dclk", {31'b0, ads_dclk}, 0);
        chk("mid_rst_irq", {31'b0, irq}, 0);
        chk("mid_rst_din", {31'b0, ads_din}, 0);
        @(negedge clk);
        reset_n = 1;
        exp_data = 0;
        rd(2, r); chk("mid_rst_data", r, 0);
        rd(1, r); chk("mid_rst_stat", r, 0);
        rd(3, r); chk("mid_rst_div", r, 25);

        // pen synchronizer latency and read-only DATA
        ads_penirq_n = 0;
        @(negedge clk);
        rd(1, r); chk("pen_one_clk", {31'b0, r[2]}, 0);
        @(negedge clk);
        rd(1, r); chk("pen_two_clk", {31'b0, r[2]}, 1);
        do_write(2, 32'hFFF);
        rd(2, r); chk("data_readonly", r, 0);
        do_write(3, 1);
        run_txn(8'($urandom), 12'($urandom), 1);

        // W1C landing on the completion cycle: set wins
        do_write(1, 32'h2);
        rd(1, r); chk("done_w1c", {31'b0, r[1]}, 0);
        dev_val = 12'($urandom);
        do_write(0, 32'h9C);
        repeat (48) @(negedge clk);
        do_write(1, 32'h2);
        rd(1, r);
        chk("done_set_wins", {31'b0, r[1]}, 1);
        chk("busy_done_same", {31'b0, r[0]}, 0);
        chk("pen_still_down", {31'b0, r[2]}, 1);
        rd(2, r); chk("data_set_wins_txn", r, {20'b0, dev_val});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
